// File: rtl/tlc_pkg.sv
// Shared definitions for the smart traffic light controller and its road-side sensors.
package tlc_pkg;

  localparam logic [1:0] TL_RED = 2'b00;
  localparam logic [1:0] TL_YEL = 2'b01;
  localparam logic [1:0] TL_GRN = 2'b10;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_RISE_CHK,
    DB_OCCUPIED,
    DB_FALL_CHK
  } db_state_t;

  // The illegal code 2'b11 falls through as non-green.
  function automatic logic is_green(input logic [1:0] ctl);
    return ctl == TL_GRN;
  endfunction

endpackage

// File: rtl/loop_debounce.sv
// Loop detector front end: 2-flop synchroniser plus a debounce FSM that strobes arrive
// once per vehicle after the loop has read occupied for DEBOUNCE consecutive checks.
module loop_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_in,
  output logic arrive
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic          loop_s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], loop_in};
  end

  assign loop_s = sync_q[1];

  // Decoded in the cycle the FSM commits to OCCUPIED, so the top can register the
  // strobe and the count together on that same edge.
  assign arrive = (state == DB_RISE_CHK) && loop_s && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        DB_IDLE: begin
          if (loop_s) begin
            state <= DB_RISE_CHK;
            cnt   <= '0;
          end
        end
        DB_RISE_CHK: begin
          if (!loop_s) begin
            state <= DB_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= DB_OCCUPIED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_OCCUPIED: begin
          if (!loop_s) begin
            state <= DB_FALL_CHK;
            cnt   <= '0;
          end
        end
        DB_FALL_CHK: begin
          if (loop_s) begin
            state <= DB_OCCUPIED;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mr_car_sensor.sv
// Main-road car counter: debounced arrivals increment MR_cars, green retires one car
// every DEPART_CYCLES clocks; count saturates and flags a sticky overflow.
module mr_car_sensor
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE      = 4,
  parameter int DEPART_CYCLES = 3,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_in,
  input  logic [1:0]       MR_ctl,
  output logic [CNT_W-1:0] MR_cars,
  output logic             car_pulse,
  output logic             overflow
);

  localparam int DW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DW-1:0]    DEP_LAST = DW'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic          arrive;
  logic          run;
  logic          depart;
  logic [DW-1:0] dep_t;

  loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .loop_in (loop_in),
    .arrive  (arrive)
  );

  // Timer only advances while there is a car to let go, so depart never hits zero.
  assign run    = is_green(MR_ctl) && (MR_cars != '0);
  assign depart = run && (dep_t == DEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dep_t     <= '0;
      MR_cars   <= '0;
      car_pulse <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      car_pulse <= arrive;

      if (!run || depart) dep_t <= '0;
      else                dep_t <= dep_t + 1'b1;

      unique case ({arrive, depart})
        2'b10: begin
          if (MR_cars == CNT_MAX) overflow <= 1'b1;
          else                    MR_cars  <= MR_cars + 1'b1;
        end
        2'b01:   MR_cars <= MR_cars - 1'b1;
        default: MR_cars <= MR_cars;
      endcase
    end
  end

endmodule
